// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register: captures the bubble-muxed control bundle and ID operands
// for the EX stage, with hold, flush and per-slot valid, plus load-use hazard detection.
module id_ex_pipe_reg #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          stall,
  input  logic          flush,
  input  logic          id_valid,
  input  logic [2:0]    id_pcsrc,
  input  logic [1:0]    id_regdst,
  input  logic          id_regwr,
  input  logic          id_alusrc1,
  input  logic          id_alusrc2,
  input  logic [5:0]    id_alufun,
  input  logic          id_sign,
  input  logic          id_memwr,
  input  logic          id_memrd,
  input  logic [1:0]    id_memtoreg,
  input  logic [DW-1:0] id_pc4,
  input  logic [DW-1:0] id_rsdata,
  input  logic [DW-1:0] id_rtdata,
  input  logic [DW-1:0] id_imm,
  input  logic [AW-1:0] id_rs,
  input  logic [AW-1:0] id_rt,
  input  logic [AW-1:0] id_rd,
  input  logic [4:0]    id_shamt,
  output logic [2:0]    ex_pcsrc,
  output logic [1:0]    ex_regdst,
  output logic          ex_regwr,
  output logic          ex_alusrc1,
  output logic          ex_alusrc2,
  output logic [5:0]    ex_alufun,
  output logic          ex_sign,
  output logic          ex_memwr,
  output logic          ex_memrd,
  output logic [1:0]    ex_memtoreg,
  output logic [DW-1:0] ex_pc4,
  output logic [DW-1:0] ex_rsdata,
  output logic [DW-1:0] ex_rtdata,
  output logic [DW-1:0] ex_imm,
  output logic [AW-1:0] ex_rs,
  output logic [AW-1:0] ex_rt,
  output logic [AW-1:0] ex_rd,
  output logic [4:0]    ex_shamt,
  output logic          ex_valid,
  output logic          load_use
);

  typedef struct packed {
    logic [2:0] pcsrc;
    logic [1:0] regdst;
    logic       regwr;
    logic       alusrc1;
    logic       alusrc2;
    logic [5:0] alufun;
    logic       sign;
    logic       memwr;
    logic       memrd;
    logic [1:0] memtoreg;
  } ctrl_t;

  ctrl_t ctrl_p0;
  ctrl_t ctrl_p1;
  logic  vld_p0;
  logic  vld_p1;
  logic  load_en;

  // ID side: squash control for flushed or invalid slots so they can never write state
  always_comb begin
    ctrl_p0 = '0;
    vld_p0  = id_valid & ~flush;
    if (vld_p0) begin
      ctrl_p0.pcsrc    = id_pcsrc;
      ctrl_p0.regdst   = id_regdst;
      ctrl_p0.regwr    = id_regwr;
      ctrl_p0.alusrc1  = id_alusrc1;
      ctrl_p0.alusrc2  = id_alusrc2;
      ctrl_p0.alufun   = id_alufun;
      ctrl_p0.sign     = id_sign;
      ctrl_p0.memwr    = id_memwr;
      ctrl_p0.memrd    = id_memrd;
      ctrl_p0.memtoreg = id_memtoreg;
    end
  end

  assign load_en = flush | ~stall;

  // ID -> EX boundary; data fields still load on flush so pc4 stays usable as EPC
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_p1   <= '0;
      vld_p1    <= 1'b0;
      ex_pc4    <= '0;
      ex_rsdata <= '0;
      ex_rtdata <= '0;
      ex_imm    <= '0;
      ex_rs     <= '0;
      ex_rt     <= '0;
      ex_rd     <= '0;
      ex_shamt  <= '0;
    end else if (load_en) begin
      ctrl_p1   <= ctrl_p0;
      vld_p1    <= vld_p0;
      ex_pc4    <= id_pc4;
      ex_rsdata <= id_rsdata;
      ex_rtdata <= id_rtdata;
      ex_imm    <= id_imm;
      ex_rs     <= id_rs;
      ex_rt     <= id_rt;
      ex_rd     <= id_rd;
      ex_shamt  <= id_shamt;
    end
  end

  assign ex_pcsrc    = ctrl_p1.pcsrc;
  assign ex_regdst   = ctrl_p1.regdst;
  assign ex_regwr    = ctrl_p1.regwr;
  assign ex_alusrc1  = ctrl_p1.alusrc1;
  assign ex_alusrc2  = ctrl_p1.alusrc2;
  assign ex_alufun   = ctrl_p1.alufun;
  assign ex_sign     = ctrl_p1.sign;
  assign ex_memwr    = ctrl_p1.memwr;
  assign ex_memrd    = ctrl_p1.memrd;
  assign ex_memtoreg = ctrl_p1.memtoreg;
  assign ex_valid    = vld_p1;

  // Self-clears: the bubble it requests loads control = 0 on the next edge
  assign load_use = ~flush & vld_p1 & ctrl_p1.memrd & (ex_rt != '0) &
                    ((ex_rt == id_rs) | (ex_rt == id_rt));

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Randomized scoreboard bench for id_ex_pipe_reg against a rule-level reference model.
module tb_id_ex_pipe_reg;

  typedef struct packed {
    logic        valid;
    logic [2:0]  pcsrc;
    logic [1:0]  regdst;
    logic        regwr;
    logic        alusrc1;
    logic        alusrc2;
    logic [5:0]  alufun;
    logic        sign;
    logic        memwr;
    logic        memrd;
    logic [1:0]  memtoreg;
    logic [31:0] pc4;
    logic [31:0] rsdata;
    logic [31:0] rtdata;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
  } slot_t;

  logic  clk = 1'b0;
  logic  reset = 1'b1;
  logic  stall = 1'b0;
  logic  flush = 1'b0;
  slot_t id = '0;
  slot_t act;
  logic  load_use;

  logic [2:0]  ex_pcsrc;
  logic [1:0]  ex_regdst;
  logic        ex_regwr, ex_alusrc1, ex_alusrc2, ex_sign, ex_memwr, ex_memrd, ex_valid;
  logic [5:0]  ex_alufun;
  logic [1:0]  ex_memtoreg;
  logic [31:0] ex_pc4, ex_rsdata, ex_rtdata, ex_imm;
  logic [4:0]  ex_rs, ex_rt, ex_rd, ex_shamt;

  int vectors = 0;
  int miscompares = 0;
  slot_t exp_q[$];
  slot_t cur = '0;

  always #5 clk = ~clk;

  id_ex_pipe_reg #(.DW(32), .AW(5)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .id_valid(id.valid), .id_pcsrc(id.pcsrc), .id_regdst(id.regdst), .id_regwr(id.regwr),
    .id_alusrc1(id.alusrc1), .id_alusrc2(id.alusrc2), .id_alufun(id.alufun),
    .id_sign(id.sign), .id_memwr(id.memwr), .id_memrd(id.memrd), .id_memtoreg(id.memtoreg),
    .id_pc4(id.pc4), .id_rsdata(id.rsdata), .id_rtdata(id.rtdata), .id_imm(id.imm),
    .id_rs(id.rs), .id_rt(id.rt), .id_rd(id.rd), .id_shamt(id.shamt),
    .ex_pcsrc(ex_pcsrc), .ex_regdst(ex_regdst), .ex_regwr(ex_regwr),
    .ex_alusrc1(ex_alusrc1), .ex_alusrc2(ex_alusrc2), .ex_alufun(ex_alufun),
    .ex_sign(ex_sign), .ex_memwr(ex_memwr), .ex_memrd(ex_memrd), .ex_memtoreg(ex_memtoreg),
    .ex_pc4(ex_pc4), .ex_rsdata(ex_rsdata), .ex_rtdata(ex_rtdata), .ex_imm(ex_imm),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_shamt(ex_shamt),
    .ex_valid(ex_valid), .load_use(load_use)
  );

  assign act = {ex_valid, ex_pcsrc, ex_regdst, ex_regwr, ex_alusrc1, ex_alusrc2, ex_alufun,
                ex_sign, ex_memwr, ex_memrd, ex_memtoreg, ex_pc4, ex_rsdata, ex_rtdata,
                ex_imm, ex_rs, ex_rt, ex_rd, ex_shamt};

  function automatic slot_t kill_ctrl(input slot_t s);
    slot_t r = s;
    r.valid = 1'b0; r.pcsrc = '0; r.regdst = '0; r.regwr = 1'b0; r.alusrc1 = 1'b0;
    r.alusrc2 = 1'b0; r.alufun = '0; r.sign = 1'b0; r.memwr = 1'b0; r.memrd = 1'b0;
    r.memtoreg = '0;
    return r;
  endfunction

  // Reference: what the EX slot should hold after one edge with these inputs
  function automatic slot_t model_next(input slot_t c, input slot_t in, input logic fl,
                                       input logic st);
    if (fl) return kill_ctrl(in);
    if (st) return c;
    if (!in.valid) return kill_ctrl(in);
    return in;
  endfunction

  function automatic logic model_lu(input slot_t c, input slot_t in, input logic fl);
    return !fl && c.valid && c.memrd && c.rt != 0 && (c.rt == in.rs || c.rt == in.rt);
  endfunction

  function automatic slot_t rand_in(input slot_t c);
    slot_t r;
    r.valid = ($urandom_range(0, 7) != 0);
    r.pcsrc = 3'($urandom); r.regdst = 2'($urandom); r.regwr = 1'($urandom);
    r.alusrc1 = 1'($urandom); r.alusrc2 = 1'($urandom); r.alufun = 6'($urandom);
    r.sign = 1'($urandom); r.memwr = 1'($urandom); r.memrd = 1'($urandom);
    r.memtoreg = 2'($urandom);
    r.pc4 = $urandom; r.rsdata = $urandom; r.rtdata = $urandom; r.imm = $urandom;
    r.rd = 5'($urandom); r.shamt = 5'($urandom);
    r.rs = ($urandom_range(0, 2) == 0) ? c.rt : 5'($urandom_range(0, 7));
    r.rt = ($urandom_range(0, 2) == 0) ? c.rt : 5'($urandom_range(0, 7));
    return r;
  endfunction

  // One cycle: drive at the falling edge, check the combinational hazard, queue the expectation
  task automatic step(input slot_t in, input logic fl, input logic st);
    logic exp_lu;
    @(negedge clk);
    id = in; flush = fl; stall = st;
    #1;
    exp_lu = model_lu(cur, in, fl);
    vectors++;
    if (load_use !== exp_lu) begin
      miscompares++;
      $display("FAIL load_use: got %b expected %b (t=%0t)", load_use, exp_lu, $time);
    end
    cur = model_next(cur, in, fl, st);
    exp_q.push_back(cur);
  endtask

  task automatic check_zero(input string name);
    vectors++;
    if (act !== '0) begin
      miscompares++;
      $display("FAIL %s: got %h expected 0", name, act);
    end
  endtask

  // Monitor: every edge that had a queued expectation gets compared shortly after
  initial begin
    slot_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        vectors++;
        if (act !== e) begin
          miscompares++;
          $display("FAIL ex_slot: got %h expected %h (t=%0t)", act, e, $time);
        end
      end
    end
  end

  initial begin
    slot_t a, b, s;
    int waited;
    #2 check_zero("reset_state");
    @(posedge clk); #3 reset = 1'b0;

    // Normal load
    s = '0; s.valid = 1'b1; s.pc4 = 32'h0040_0004; s.rsdata = 32'hDEAD_BEEF;
    s.memtoreg = 2'b01; s.memrd = 1'b1; s.rt = 5'd9;
    step(s, 1'b0, 1'b0);

    // Stall hold: A, then 3 stalled cycles presenting B, then B lands
    a = rand_in(cur); a.valid = 1'b1;
    b = rand_in(cur); b.valid = 1'b1;
    step(a, 1'b0, 1'b0);
    repeat (3) step(b, 1'b0, 1'b1);
    step(b, 1'b0, 1'b0);

    // Flush beats stall
    s = '0; s.valid = 1'b1; s.regwr = 1'b1; s.memwr = 1'b1; s.pc4 = 32'h100;
    step(s, 1'b1, 1'b1);

    // Load-use: lw with rt=5, then consumer with rs=5; rt=0 variant; flush variant
    s = '0; s.valid = 1'b1; s.memrd = 1'b1; s.rt = 5'd5;
    step(s, 1'b0, 1'b0);
    s = '0; s.valid = 1'b1; s.rs = 5'd5;
    step(s, 1'b0, 1'b1);
    step(s, 1'b1, 1'b0);
    s = '0; s.valid = 1'b1; s.memrd = 1'b1; s.rt = 5'd0;
    step(s, 1'b0, 1'b0);
    s = '0; s.valid = 1'b1; s.rs = 5'd0; s.rt = 5'd0;
    step(s, 1'b0, 1'b0);

    // Invalid slot never carries control
    s = rand_in(cur); s.valid = 1'b0; s.regwr = 1'b1; s.memwr = 1'b1;
    step(s, 1'b0, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      s = rand_in(cur);
      step(s, ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0));
    end

    // Asynchronous reset between edges after a live load
    s = '0; s.valid = 1'b1; s.alufun = 6'h21; s.regwr = 1'b1;
    step(s, 1'b0, 1'b0);
    @(posedge clk); #3 reset = 1'b1;
    #1 check_zero("async_reset");
    @(posedge clk); #3 reset = 1'b0;
    cur = '0;
    #1 check_zero("reset_held");
    for (int i = 0; i < 20; i++) begin
      s = rand_in(cur);
      step(s, 1'b0, ($urandom_range(0, 3) == 0));
    end

    waited = 0;
    while (exp_q.size() != 0 && waited < 10) begin
      @(posedge clk); #2;
      waited++;
    end
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/id_ex_pipe_reg.md
Name: id_ex_pipe_reg

Overview:
- ID/EX pipeline register. It captures the decoded control bundle after bubble-muxing, plus the ID-stage operands, and presents them to the EX stage.
- Supports hold (stall) and flush (bubble insert), and tracks a valid bit per slot.
- Generates the load-use hazard request that drives the ID-stage bubble select and the PC/IF-ID stall.

Parameters:
- DW, 32, datapath width (operands, immediate, PC+4)
- AW, 5, register address width

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- stall  in  1  hold current contents (from EX/MEM-side stall)
- flush  in  1  load a bubble this cycle (branch/jump resolve, exception)
- id_valid  in  1  ID slot holds a real instruction
- id_pcsrc  in  3  PC source select
- id_regdst  in  2  destination register select
- id_regwr  in  1  register write enable
- id_alusrc1  in  1  ALU A select
- id_alusrc2  in  1  ALU B select
- id_alufun  in  6  ALU function
- id_sign  in  1  signed compare/overflow
- id_memwr  in  1  memory write
- id_memrd  in  1  memory read
- id_memtoreg  in  2  writeback select
- id_pc4  in  DW  PC+4 of ID instruction
- id_rsdata  in  DW  rs operand
- id_rtdata  in  DW  rt operand
- id_imm  in  DW  extended/LUI-shifted immediate
- id_rs, id_rt, id_rd  in  AW each  register addresses
- id_shamt  in  5  shift amount
- ex_* (one per id_* above, same width)  out  registered copy
- ex_valid  out  1  EX slot holds a real instruction
- load_use  out  1  load-use hazard: insert bubble in ID, hold PC and IF/ID

Behaviour:
- Priority per rising edge: reset > flush > stall > load.
- Reset (async, immediate on assertion): all ex_* outputs = 0, ex_valid = 0. Held while reset is high; first load occurs on the first rising edge after deassertion.
- flush = 1: every control output (pcsrc, regdst, regwr, alusrc1/2, alufun, sign, memwr, memrd, memtoreg) = 0 and ex_valid = 0. Data fields (pc4, rsdata, rtdata, imm, rs, rt, rd, shamt) are still loaded from id_*, so pc4 remains available for exception EPC.
- flush and stall both = 1: flush wins.
- stall = 1, flush = 0: all registers keep their value; no partial update.
- Normal load: all ex_* <= id_*; ex_valid <= id_valid.
- id_valid = 0 on load: control fields are forced to 0 regardless of id_* values, so an invalid slot never writes regfile or memory.
- Latency: exactly one cycle from id_* to ex_*.
- load_use (combinational from registered state plus ID addresses) = ex_valid & ex_memrd & (ex_rt != 0) & ((ex_rt == id_rs) | (ex_rt == id_rt)).
- load_use is forced 0 while flush = 1, because the instruction in ID is being squashed.
- load_use drives the ID-stage bubble select. On the next edge this block loads a bubble (control = 0) from the muxed inputs, so load_use self-clears after one cycle. The block adds no extra state for this.
- No combinational path from id_* to ex_*. The only input-to-output combinational paths are id_rs/id_rt/flush -> load_use.

Test Plan:
- Reset mid-operation: load alufun=6'h21, regwr=1, then assert reset asynchronously between edges -> all ex_* = 0 and ex_valid = 0 immediately, before the next edge.
- Normal load: id_pc4=32'h0040_0004, id_rsdata=32'hDEAD_BEEF, memtoreg=2'b01, memrd=1, id_valid=1 -> same values on ex_* one edge later, ex_valid=1.
- Stall hold: load value A, then stall=1 for 3 cycles while id_* = B -> ex_* stay A all 3 cycles; first edge after stall drops -> ex_* = B.
- Flush vs stall: flush=1, stall=1, id_regwr=1, id_memwr=1, id_pc4=32'h100 -> ex_regwr=0, ex_memwr=0, ex_valid=0, ex_pc4=32'h100.
- Load-use: ex holds lw (memrd=1, ex_rt=5, valid) and id_rs=5 -> load_use=1. Same with ex_rt=0 -> load_use=0. Same with flush=1 -> load_use=0.
- Invalid slot: id_valid=0 with id_regwr=1, id_memwr=1 -> ex_regwr=0, ex_memwr=0, ex_valid=0.
